// File: rtl/rx_pkt_seq_ctrl_if.sv
// AXI-stream style output bus of the rx packet sequencer.
interface rx_pkt_seq_ctrl_if;
    logic [63:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        tuser;
    logic        tready;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/rx_pkt_seq_ctrl.sv
// Per-packet rx sequencer: admission on FIFO space, header word, payload forwarding,
// abort/watchdog termination and completion pulse back to the byte-to-word packer.
module rx_pkt_seq_ctrl #(
    parameter int unsigned FIFO_AW  = 9,
    parameter int unsigned WDOG_CYC = 4096
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               pkt_hdr_valid_i,
    input  logic [15:0]        pkt_len_i,
    input  logic [31:0]        tsf_lo_i,
    input  logic [15:0]        rssi_i,
    input  logic [63:0]        word_in_i,
    input  logic               word_in_strobe_i,
    input  logic               pkt_abort_i,
    output logic [15:0]        num_byte_o,
    output logic               rx_pkt_sn_plus_one_o,
    rx_pkt_seq_ctrl_if.master  m_axis,
    output logic [15:0]        drop_cnt_o,
    output logic [15:0]        abort_cnt_o
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CW    = FIFO_AW + 1;
    localparam int unsigned WDW   = $clog2(WDOG_CYC + 1);
    localparam int unsigned LW    = 17;

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_TERM, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [15:0]          num_byte_q;
    logic [31:0]          tsf_q;
    logic [15:0]          rssi_q;
    logic [LW-1:0]        need_q;
    logic [LW-1:0]        acc_q, acc_d;
    logic                 skid_v_q, skid_v_d;
    logic                 skid_last_q, skid_last_d;
    logic [63:0]          skid_data_q, skid_data_d;
    logic [WDW-1:0]       wdog_q, wdog_d;
    logic [15:0]          drop_q, abort_q;
    logic                 sn_q;

    logic [63:0]          mem_data [DEPTH];
    logic                 mem_last [DEPTH];
    logic                 mem_user [DEPTH];
    logic [FIFO_AW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]        cnt_q;

    logic                 wr_en, wr_last, wr_user, rd_en;
    logic [63:0]          wr_data;
    logic                 latch_hdr, drop_inc, abort_inc;
    logic                 acc_ok, acc_last, hold_last, wdog_hit;
    logic [LW-1:0]        pay_words, nwords, free_ent;
    logic                 admit;

    // Admission arithmetic: payload words, total words and free entries (reads not yet freed).
    always_comb begin
        pay_words = LW'((LW'(pkt_len_i) + LW'(7)) >> 3);
        nwords    = pay_words + LW'(1);
        free_ent  = LW'(DEPTH) - LW'(cnt_q);
        admit     = (pkt_len_i != 16'd0) && (nwords <= free_ent);
        rd_en     = (cnt_q != '0) && m_axis.tready;
        acc_ok    = word_in_strobe_i && (acc_q < need_q);
        acc_last  = (acc_q + LW'(1)) == need_q;
        wdog_hit  = wdog_q == WDW'(WDOG_CYC);
    end

    // Next-state, FIFO write selection and payload skid handling.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        skid_v_d    = skid_v_q;
        skid_last_d = skid_last_q;
        skid_data_d = skid_data_q;
        wdog_d      = wdog_q;
        wr_en       = 1'b0;
        wr_data     = '0;
        wr_last     = 1'b0;
        wr_user     = 1'b0;
        latch_hdr   = 1'b0;
        drop_inc    = 1'b0;
        abort_inc   = 1'b0;
        hold_last   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (pkt_hdr_valid_i) begin
                    if (admit) begin
                        latch_hdr = 1'b1;
                        acc_d     = '0;
                        skid_v_d  = 1'b0;
                        wdog_d    = '0;
                        state_d   = S_HDR;
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
            end
            S_HDR: begin
                drop_inc = pkt_hdr_valid_i;
                wr_en    = 1'b1;
                wr_data  = {rssi_q, num_byte_q, tsf_q};
                wdog_d   = '0;
                if (pkt_abort_i) begin
                    state_d = S_TERM;
                end else begin
                    state_d = S_DATA;
                    if (acc_ok) begin
                        skid_v_d    = 1'b1;
                        skid_data_d = word_in_i;
                        skid_last_d = acc_last;
                        acc_d       = acc_q + LW'(1);
                    end
                end
            end
            S_DATA: begin
                drop_inc = pkt_hdr_valid_i;
                wdog_d   = word_in_strobe_i ? '0 : wdog_q + WDW'(1);
                if (skid_v_q) begin
                    // Skidded word drains first; a new word refills the skid behind it.
                    wr_en   = 1'b1;
                    wr_data = skid_data_q;
                    wr_last = skid_last_q;
                    if (acc_ok) begin
                        skid_data_d = word_in_i;
                        skid_last_d = acc_last;
                        acc_d       = acc_q + LW'(1);
                        hold_last   = acc_last;
                    end else begin
                        skid_v_d = 1'b0;
                    end
                end else if (acc_ok) begin
                    wr_en   = 1'b1;
                    wr_data = word_in_i;
                    wr_last = acc_last;
                    acc_d   = acc_q + LW'(1);
                end
                // Final word beats a coincident abort.
                if (wr_en && wr_last) begin
                    state_d = S_DONE;
                end else if ((pkt_abort_i || wdog_hit) && !hold_last) begin
                    skid_v_d = 1'b0;
                    state_d  = S_TERM;
                end
            end
            S_TERM: begin
                drop_inc  = pkt_hdr_valid_i;
                wr_en     = 1'b1;
                wr_data   = 64'hDEAD_DEAD_DEAD_DEAD;
                wr_last   = 1'b1;
                wr_user   = 1'b1;
                abort_inc = 1'b1;
                state_d   = S_IDLE;
            end
            S_DONE: begin
                drop_inc = pkt_hdr_valid_i;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state, counters and FIFO pointers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            num_byte_q  <= '0;
            tsf_q       <= '0;
            rssi_q      <= '0;
            need_q      <= '0;
            acc_q       <= '0;
            skid_v_q    <= 1'b0;
            skid_last_q <= 1'b0;
            skid_data_q <= '0;
            wdog_q      <= '0;
            drop_q      <= '0;
            abort_q     <= '0;
            sn_q        <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            skid_v_q    <= skid_v_d;
            skid_last_q <= skid_last_d;
            skid_data_q <= skid_data_d;
            wdog_q      <= wdog_d;
            sn_q        <= (state_d == S_DONE);
            if (latch_hdr) begin
                num_byte_q <= pkt_len_i;
                tsf_q      <= tsf_lo_i;
                rssi_q     <= rssi_i;
                need_q     <= pay_words;
            end
            if (drop_inc && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
            if (abort_inc && (abort_q != 16'hFFFF)) abort_q <= abort_q + 16'd1;
            if (wr_en) wptr_q <= wptr_q + FIFO_AW'(1);
            if (rd_en) rptr_q <= rptr_q + FIFO_AW'(1);
            cnt_q <= cnt_q + CW'(wr_en) - CW'(rd_en);
        end
    end

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_data[wptr_q] <= wr_data;
            mem_last[wptr_q] <= wr_last;
            mem_user[wptr_q] <= wr_user;
        end
    end

    assign m_axis.tvalid        = (cnt_q != '0);
    assign m_axis.tdata         = m_axis.tvalid ? mem_data[rptr_q] : '0;
    assign m_axis.tlast         = m_axis.tvalid ? mem_last[rptr_q] : 1'b0;
    assign m_axis.tuser         = m_axis.tvalid ? mem_user[rptr_q] : 1'b0;
    assign num_byte_o           = num_byte_q;
    assign rx_pkt_sn_plus_one_o = sn_q;
    assign drop_cnt_o           = drop_q;
    assign abort_cnt_o          = abort_q;

endmodule

// File: tb/tb_rx_pkt_seq_ctrl.sv
// Directed bench for rx_pkt_seq_ctrl with a small FIFO and short watchdog.
module tb_rx_pkt_seq_ctrl;

    localparam int unsigned FIFO_AW  = 4;
    localparam int unsigned WDOG_CYC = 64;
    localparam logic [63:0] DEAD     = 64'hDEAD_DEAD_DEAD_DEAD;

    logic        clk;
    logic        rstn;
    logic        pkt_hdr_valid;
    logic [15:0] pkt_len;
    logic [31:0] tsf_lo;
    logic [15:0] rssi;
    logic [63:0] word_in;
    logic        word_in_strobe;
    logic        pkt_abort;
    logic [15:0] num_byte;
    logic        sn_pulse;
    logic [15:0] drop_cnt;
    logic [15:0] abort_cnt;

    rx_pkt_seq_ctrl_if axis ();

    rx_pkt_seq_ctrl #(.FIFO_AW(FIFO_AW), .WDOG_CYC(WDOG_CYC)) dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .pkt_hdr_valid_i      (pkt_hdr_valid),
        .pkt_len_i            (pkt_len),
        .tsf_lo_i             (tsf_lo),
        .rssi_i               (rssi),
        .word_in_i            (word_in),
        .word_in_strobe_i     (word_in_strobe),
        .pkt_abort_i          (pkt_abort),
        .num_byte_o           (num_byte),
        .rx_pkt_sn_plus_one_o (sn_pulse),
        .m_axis               (axis.master),
        .drop_cnt_o           (drop_cnt),
        .abort_cnt_o          (abort_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    int          sn_cnt      = 0;
    logic [65:0] beats [$];

    // Beat and completion-pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rstn && axis.tvalid && axis.tready) beats.push_back({axis.tuser, axis.tlast, axis.tdata});
        if (rstn && sn_pulse) sn_cnt++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [63:0] d, input logic l, input logic u);
        logic [65:0] b;
        chk({tag, "_present"}, 66'(beats.size() != 0), 66'd1);
        if (beats.size() != 0) begin
            b = beats.pop_front();
            chk(tag, b, {u, l, d});
        end
    endtask

    task automatic pulse_hdr(input logic [15:0] len, input logic [31:0] tsf, input logic [15:0] rs);
        pkt_len       = len;
        tsf_lo        = tsf;
        rssi          = rs;
        pkt_hdr_valid = 1'b1;
        tick();
        pkt_hdr_valid = 1'b0;
    endtask

    task automatic strobe(input logic [63:0] w);
        word_in        = w;
        word_in_strobe = 1'b1;
        tick();
        word_in_strobe = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; pkt_hdr_valid = 1'b0; pkt_len = '0; tsf_lo = '0; rssi = '0;
        word_in = '0; word_in_strobe = 1'b0; pkt_abort = 1'b0; axis.tready = 1'b1;
        tick(3);
        rstn = 1'b1;
        tick();
        chk("rst_tvalid", 66'(axis.tvalid), 66'd0);
        chk("rst_tdata", 66'(axis.tdata), 66'd0);
        chk("rst_num_byte", 66'(num_byte), 66'd0);
        chk("rst_drop", 66'(drop_cnt), 66'd0);
        chk("rst_abort", 66'(abort_cnt), 66'd0);
        chk("rst_sn", 66'(sn_pulse), 66'd0);

        // Test 1: pkt_len=20 -> header + 3 words
        pulse_hdr(16'd20, 32'h1111_2222, 16'hABCD);
        chk("t1_tvalid_early", 66'(axis.tvalid), 66'd0);
        tick();
        chk("t1_hdr_latency", 66'({axis.tvalid, axis.tdata}), {2'b01, 64'hABCD_0014_1111_2222});
        chk("t1_num_byte", 66'(num_byte), 66'd20);
        strobe(64'hA1); tick(); strobe(64'hA2); tick(); strobe(64'hA3); tick(4);
        chk_beat("t1_b0", 64'hABCD_0014_1111_2222, 1'b0, 1'b0);
        chk_beat("t1_b1", 64'hA1, 1'b0, 1'b0);
        chk_beat("t1_b2", 64'hA2, 1'b0, 1'b0);
        chk_beat("t1_b3", 64'hA3, 1'b1, 1'b0);
        chk("t1_sn", 66'(sn_cnt), 66'd1);
        chk("t1_left", 66'(beats.size()), 66'd0);

        // Test 2: pkt_len=16, strobe in header cycle, stray third strobe
        pulse_hdr(16'd16, 32'h2000_0002, 16'h2222);
        strobe(64'hB1); strobe(64'hB2); strobe(64'hB3); tick(4);
        chk_beat("t2_b0", 64'h2222_0010_2000_0002, 1'b0, 1'b0);
        chk_beat("t2_b1", 64'hB1, 1'b0, 1'b0);
        chk_beat("t2_b2", 64'hB2, 1'b1, 1'b0);
        chk("t2_sn", 66'(sn_cnt), 66'd2);
        chk("t2_left", 66'(beats.size()), 66'd0);
        pulse_hdr(16'd0, 32'h0, 16'h0);
        tick(2);
        chk("t2_len0_drop", 66'(drop_cnt), 66'd1);
        chk("t2_len0_nobeat", 66'(beats.size()), 66'd0);
        chk("t2_len0_nosn", 66'(sn_cnt), 66'd2);

        // Test 3: fill 14 of 16 entries with tready=0, 6-word packet is dropped
        axis.tready = 1'b0;
        pulse_hdr(16'd100, 32'h3000_0003, 16'h3333);
        for (int i = 0; i < 13; i++) strobe(64'hC000_0000_0000_0000 + 64'(i));
        tick(3);
        pulse_hdr(16'd40, 32'h4000_0004, 16'h4444);
        tick(2);
        chk("t3_drop", 66'(drop_cnt), 66'd2);
        chk("t3_num_byte", 66'(num_byte), 66'd100);
        chk("t3_head_stable", 66'({axis.tvalid, axis.tdata}), {2'b01, 64'h3333_0064_3000_0003});
        axis.tready = 1'b1;
        tick(20);
        chk_beat("t3_hdr", 64'h3333_0064_3000_0003, 1'b0, 1'b0);
        for (int i = 0; i < 13; i++)
            chk_beat($sformatf("t3_w%0d", i), 64'hC000_0000_0000_0000 + 64'(i), (i == 12), 1'b0);
        chk("t3_sn", 66'(sn_cnt), 66'd3);
        chk("t3_left", 66'(beats.size()), 66'd0);

        // Test 4: pkt_len=64 aborted after 3 words; header during DATA is dropped
        pulse_hdr(16'd64, 32'h5000_0005, 16'h5555);
        tick();
        strobe(64'hD1); tick(); strobe(64'hD2); tick(); strobe(64'hD3);
        pulse_hdr(16'd8, 32'h0, 16'h0);
        pkt_abort = 1'b1; tick(); pkt_abort = 1'b0;
        tick(4);
        chk_beat("t4_hdr", 64'h5555_0040_5000_0005, 1'b0, 1'b0);
        chk_beat("t4_w1", 64'hD1, 1'b0, 1'b0);
        chk_beat("t4_w2", 64'hD2, 1'b0, 1'b0);
        chk_beat("t4_w3", 64'hD3, 1'b0, 1'b0);
        chk_beat("t4_term", DEAD, 1'b1, 1'b1);
        chk("t4_drop", 66'(drop_cnt), 66'd3);
        chk("t4_abort", 66'(abort_cnt), 66'd1);
        chk("t4_sn", 66'(sn_cnt), 66'd3);
        chk("t4_left", 66'(beats.size()), 66'd0);

        // Test 5: watchdog abort, then abort coinciding with final word
        pulse_hdr(16'd24, 32'h6000_0006, 16'h6666);
        tick();
        strobe(64'hE1);
        tick(WDOG_CYC + 16);
        chk_beat("t5_hdr", 64'h6666_0018_6000_0006, 1'b0, 1'b0);
        chk_beat("t5_w1", 64'hE1, 1'b0, 1'b0);
        chk_beat("t5_term", DEAD, 1'b1, 1'b1);
        chk("t5_abort", 66'(abort_cnt), 66'd2);
        chk("t5_sn_wdog", 66'(sn_cnt), 66'd3);
        pulse_hdr(16'd8, 32'h7000_0007, 16'h7777);
        tick();
        word_in = 64'hF1; word_in_strobe = 1'b1; pkt_abort = 1'b1;
        tick();
        word_in_strobe = 1'b0; pkt_abort = 1'b0;
        tick(4);
        chk_beat("t5_hdr2", 64'h7777_0008_7000_0007, 1'b0, 1'b0);
        chk_beat("t5_last_wins", 64'hF1, 1'b1, 1'b0);
        chk("t5_sn", 66'(sn_cnt), 66'd4);
        chk("t5_abort_keep", 66'(abort_cnt), 66'd2);
        chk("t5_left", 66'(beats.size()), 66'd0);

        // Test 6: reset mid-DATA with data pending
        axis.tready = 1'b0;
        pulse_hdr(16'd24, 32'h8000_0008, 16'h8888);
        tick();
        strobe(64'h91);
        chk("t6_pre_tvalid", 66'(axis.tvalid), 66'd1);
        rstn = 1'b0;
        tick();
        chk("t6_tvalid", 66'(axis.tvalid), 66'd0);
        chk("t6_num_byte", 66'(num_byte), 66'd0);
        chk("t6_drop", 66'(drop_cnt), 66'd0);
        chk("t6_abort", 66'(abort_cnt), 66'd0);
        chk("t6_sn_out", 66'(sn_pulse), 66'd0);
        rstn = 1'b1;
        axis.tready = 1'b1;
        tick();
        pulse_hdr(16'd8, 32'h9000_0009, 16'h9999);
        tick();
        strobe(64'h92);
        tick(4);
        chk_beat("t6_hdr", 64'h9999_0008_9000_0009, 1'b0, 1'b0);
        chk_beat("t6_w1", 64'h92, 1'b1, 1'b0);
        chk("t6_sn", 66'(sn_cnt), 66'd5);
        chk("t6_left", 66'(beats.size()), 66'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
